pipe_add: RTL and testbench
===========================

PIPE_ADD -- requirements
Module: pipe_add

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; SHALL be a multiple of LANE.
REQ-002 Parameter LANE, default 4: bits added per pipeline stage; STAGES = WIDTH/LANE.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  operand beat accepted when in_valid && in_ready.
REQ-007 a  input  WIDTH  operand A, unsigned or two's complement.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in; ignored when sub=1.
REQ-010 sub  input  1  0: a+b+cin; 1: a-b, computed as a+~b+1.
REQ-011 out_valid  output  1  result beat present.
REQ-012 out_ready  input  1  consumer accepts result when out_valid && out_ready.
REQ-013 sum  output  WIDTH  result bits.
REQ-014 cout  output  1  carry-out of the MSB; for sub, 1 means no borrow.

Function
REQ-015 Datapath SHALL be a STAGES-deep pipeline; stage k adds lane k (bits k*LANE..k*LANE+LANE-1) using the carry registered by stage k-1.
REQ-016 Operand lanes not yet consumed and completed sum lanes SHALL be carried in skew registers alongside each stage.
REQ-017 Latency SHALL be exactly STAGES cycles from an accepted input to out_valid, absent backpressure.
REQ-018 Throughput SHALL be one beat per cycle when out_ready is held high.
REQ-019 Pipeline advance signal adv = !out_valid || out_ready; all stage registers and valid bits shift only when adv=1.
REQ-020 in_ready SHALL equal adv, combinationally; no combinational path from in_valid to in_ready.
REQ-021 While out_valid=1 and out_ready=0, sum, cout and out_valid SHALL hold stable.
REQ-022 Bubbles (in_valid=0 during advance) SHALL propagate as valid=0 slots; they SHALL NOT be compressed.
REQ-023 Arithmetic is modulo 2^WIDTH in sum; cout is bit WIDTH of the full result.
REQ-024 Simultaneous accept and emit in the same cycle SHALL both occur with no lost or duplicated beat.
REQ-025 WIDTH==LANE (STAGES=1) SHALL yield a single registered stage with latency 1.

Reset
REQ-026 rst_n low SHALL clear every stage valid bit, out_valid=0, sum=0, cout=0 (and ovf=0 when present) immediately.
REQ-027 Reset mid-operation SHALL discard all in-flight beats; none emerge after release.
REQ-028 in_ready SHALL read 1 during and after reset (pipeline empty).

Configuration
REQ-029 Macro PIPE_ADD_OVF_EN defined: extra output ovf (1 bit) SHALL be asserted with the result when signed two's-complement overflow occurred (carry into MSB != carry out of MSB), aligned to sum.
REQ-030 Macro PIPE_ADD_OVF_EN undefined: port ovf and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-031 Package pipe_add_pkg SHALL hold default WIDTH/LANE constants and a STAGES derivation function.
REQ-032 One sub-module add_lane SHALL implement a LANE-bit ripple carry add (a, b, cin -> s, cout), instantiated once per stage.
REQ-033 Elaboration SHALL fail if WIDTH mod LANE != 0 or LANE < 1.

Verification (WIDTH=8, LANE=4, latency 2)
REQ-034 a=0x3C, b=0x05, cin=0, sub=0, out_ready=1 -> two cycles later sum=0x41, cout=0.
REQ-035 a=0xFF, b=0x01, cin=1 -> sum=0x01, cout=1; a=0x10, b=0x20, sub=1 -> sum=0xF0, cout=0 (borrow).
REQ-036 Back-to-back 4 beats, out_ready low cycles 3-5 -> in_ready low those cycles, outputs held, all 4 results in order, none lost.
REQ-037 rst_n pulsed low while 2 beats in flight -> out_valid=0 immediately, no result emerges after release.
REQ-038 With PIPE_ADD_OVF_EN: a=0x7F, b=0x01 -> sum=0x80, ovf=1; a=0x80, b=0xFF -> sum=0x7F, cout=1, ovf=1; a=0x01, b=0x01 -> ovf=0.

Source files
------------

// File: rtl/pipe_add_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_add_pkg
// Purpose  : Default geometry and stage-count derivation for pipe_add.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_add_pkg;

   localparam int c_DEF_WIDTH = 8;
   localparam int c_DEF_LANE  = 4;

   function automatic int stages_of(input int width, input int lane);
      return (lane > 0) ? width / lane : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/add_lane.sv
`default_nettype none
// ============================================================================
// Module   : add_lane
// Purpose  : LANE-bit ripple-carry adder slice used by each pipe_add stage.
// Revision : 1.0 - initial release
// ============================================================================
module add_lane
   import pipe_add_pkg::*;
#(
   parameter int LANE = c_DEF_LANE
) (
   input  logic [LANE-1:0] a,
   input  logic [LANE-1:0] b,
   input  logic            cin,
   output logic [LANE-1:0] s,
   output logic            cout
);

   logic [LANE:0] w_c;

   assign w_c[0] = cin;

   for (genvar i = 0; i < LANE; i++) begin : g_bit
      assign s[i]     = a[i] ^ b[i] ^ w_c[i];
      assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
   end

   assign cout = w_c[LANE];

endmodule
`default_nettype wire

// File: rtl/pipe_add.sv
`default_nettype none
// ============================================================================
// Module   : pipe_add
// Purpose  : Lane-pipelined add/subtract with valid/ready flow control.
//            Define PIPE_ADD_OVF_EN to add the signed-overflow output ovf.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_add
   import pipe_add_pkg::*;
#(
   parameter int WIDTH = c_DEF_WIDTH,
   parameter int LANE  = c_DEF_LANE
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef PIPE_ADD_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int STAGES = stages_of(WIDTH, LANE);

   if (LANE < 1 || (WIDTH % LANE) != 0) begin : g_bad_params
      $error("pipe_add: WIDTH must be a positive multiple of LANE");
   end

   logic             w_adv;
   logic [WIDTH-1:0] w_b_eff;
   logic             w_cin_eff;

   assign w_adv     = !out_valid || out_ready;
   assign in_ready  = w_adv;
   assign w_b_eff   = sub ? ~b : b;
   assign w_cin_eff = sub | cin;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int c_DONE = (k + 1) * LANE;
      localparam int c_IN_W = WIDTH - k * LANE;

      // Operands entering this stage with lane k aligned at bit 0.
      logic [c_IN_W-1:0] w_ain;
      logic [c_IN_W-1:0] w_bin;
      logic              w_ci;
      logic              w_vin;
      logic [LANE-1:0]   w_ls;
      logic              w_co;
      logic [c_DONE-1:0] w_sum_next;
      logic              r_valid;
      logic              r_carry;
      logic [c_DONE-1:0] r_sum;

      if (k == 0) begin : g_first
         assign w_ain      = a;
         assign w_bin      = w_b_eff;
         assign w_ci       = w_cin_eff;
         assign w_vin      = in_valid;
         assign w_sum_next = w_ls;
      end else begin : g_rest
         assign w_ain      = g_stage[k-1].g_ops.r_a_rem;
         assign w_bin      = g_stage[k-1].g_ops.r_b_rem;
         assign w_ci       = g_stage[k-1].r_carry;
         assign w_vin      = g_stage[k-1].r_valid;
         assign w_sum_next = {w_ls, g_stage[k-1].r_sum};
      end

      add_lane #(.LANE(LANE)) u_lane (
         .a    (w_ain[LANE-1:0]),
         .b    (w_bin[LANE-1:0]),
         .cin  (w_ci),
         .s    (w_ls),
         .cout (w_co)
      );

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_valid <= 1'b0;
            r_carry <= 1'b0;
            r_sum   <= '0;
         end else if (w_adv) begin
            r_valid <= w_vin;
            r_carry <= w_co;
            r_sum   <= w_sum_next;
         end
      end

      if (k < STAGES - 1) begin : g_ops
         logic [WIDTH-c_DONE-1:0] r_a_rem;
         logic [WIDTH-c_DONE-1:0] r_b_rem;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_a_rem <= '0;
               r_b_rem <= '0;
            end else if (w_adv) begin
               r_a_rem <= w_ain[c_IN_W-1:LANE];
               r_b_rem <= w_bin[c_IN_W-1:LANE];
            end
         end
      end

`ifdef PIPE_ADD_OVF_EN
      if (k == STAGES - 1) begin : g_ovf
         logic r_ovf;

         // Carry into the MSB is recovered as s ^ a ^ b at that bit.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_ovf <= 1'b0;
            end else if (w_adv) begin
               r_ovf <= w_co ^ w_ls[LANE-1] ^ w_ain[LANE-1] ^ w_bin[LANE-1];
            end
         end
      end
`endif
   end

   assign out_valid = g_stage[STAGES-1].r_valid;
   assign sum       = g_stage[STAGES-1].r_sum;
   assign cout      = g_stage[STAGES-1].r_carry;
`ifdef PIPE_ADD_OVF_EN
   assign ovf       = g_stage[STAGES-1].g_ovf.r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_add.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_add
// Purpose  : Randomized scoreboard bench for pipe_add (WIDTH=8, LANE=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_add;

   localparam int WIDTH  = 8;
   localparam int LANE   = 4;
   localparam int STAGES = WIDTH / LANE;

   logic             clk       = 1'b0;
   logic             rst_n     = 1'b1;
   logic             in_valid  = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a         = '0;
   logic [WIDTH-1:0] b         = '0;
   logic             cin       = 1'b0;
   logic             sub       = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef PIPE_ADD_OVF_EN
   logic             ovf;
`endif

   typedef struct {
      logic [WIDTH-1:0] sum;
      logic             cout;
      logic             ovf;
      int               cyc;
      bit               chk_lat;
   } exp_t;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic       ci;
      logic       s;
      logic [7:0] sum;
      logic       co;
      logic       ov;
   } vec_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   bit   lat_mode = 1'b0;

   pipe_add #(.WIDTH(WIDTH), .LANE(LANE)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
`ifdef PIPE_ADD_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: plain integer arithmetic on the effective operands.
   function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                  input logic ci, input logic s);
      exp_t           e;
      logic [WIDTH-1:0] yb;
      logic [WIDTH:0]   full;
      int             c;
      int             sx;
      yb     = s ? ~y : y;
      c      = (s || ci) ? 1 : 0;
      full   = {1'b0, x} + {1'b0, yb} + (WIDTH+1)'(c);
      sx     = int'($signed(x)) + int'($signed(yb)) + c;
      e.sum  = full[WIDTH-1:0];
      e.cout = full[WIDTH];
      e.ovf  = (sx > (2**(WIDTH-1)) - 1) || (sx < -(2**(WIDTH-1)));
      e.cyc  = 0;
      e.chk_lat = 1'b0;
      return e;
   endfunction

   function automatic logic [WIDTH-1:0] rnd_op();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return '1;
         2:       return {1'b1, {(WIDTH-1){1'b0}}};
         3:       return {1'b0, {(WIDTH-1){1'b1}}};
         default: return WIDTH'($urandom);
      endcase
   endfunction

   // One cycle of stimulus; the expected result is queued when the beat is accepted.
   task automatic offer(input logic v, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic ci, input logic s, input logic ordy,
                        input bit use_exp, input exp_t ex, output bit acc);
      exp_t e;
      @(negedge clk);
      in_valid  = v;
      a         = x;
      b         = y;
      cin       = ci;
      sub       = s;
      out_ready = ordy;
      #2;
      acc = v && in_ready && rst_n;
      if (acc) begin
         e         = use_exp ? ex : model(x, y, ci, s);
         e.cyc     = cyc;
         e.chk_lat = lat_mode;
         sb.push_back(e);
      end
   endtask

   task automatic drain();
      bit   acc;
      exp_t none;
      none = '{default: '0};
      for (int i = 0; i < 20 && sb.size() != 0; i++)
         offer(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, none, acc);
      offer(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, none, acc);
      check("drain_empty", sb.size(), 0);
   endtask

   initial begin : monitor
      exp_t             e;
      logic [WIDTH-1:0] h_sum;
      logic             h_cout;
      bit               held;
      held = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            held = 1'b0;
            continue;
         end
         check("in_ready_adv", in_ready, !out_valid || out_ready);
         if (held) begin
            check("hold_valid", out_valid, 1);
            check("hold_sum", sum, h_sum);
            check("hold_cout", cout, h_cout);
         end
         held   = out_valid && !out_ready;
         h_sum  = sum;
         h_cout = cout;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_beat", out_valid, 0);
            end else begin
               e = sb.pop_front();
               check("sum", sum, e.sum);
               check("cout", cout, e.cout);
`ifdef PIPE_ADD_OVF_EN
               check("ovf", ovf, e.ovf);
`endif
               if (e.chk_lat) check("latency", cyc - e.cyc, STAGES);
            end
         end
      end
   end

   initial begin : stim
      bit               acc;
      bit               pend;
      exp_t             none;
      exp_t             ex;
      vec_t             dir [7];
      logic [WIDTH-1:0] bx [4];
      logic [WIDTH-1:0] by [4];
      logic [WIDTH-1:0] rx, ry;
      logic             rc, rs, rv;
      int               sent;

      none = '{default: '0};
      dir[0] = '{8'h3C, 8'h05, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0};
      dir[1] = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
      dir[2] = '{8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0};
      dir[3] = '{8'h20, 8'h10, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0};
      dir[4] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
      dir[5] = '{8'h80, 8'hFF, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b1};
      dir[6] = '{8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0};

      // Asynchronous reset: outputs must clear before any clock edge.
      #1 rst_n = 1'b0;
      #2;
      check("rst_out_valid", out_valid, 0);
      check("rst_sum", sum, 0);
      check("rst_cout", cout, 0);
      check("rst_in_ready", in_ready, 1);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;

      // Directed vectors with the consumer always ready (exact latency).
      lat_mode = 1'b1;
      for (int i = 0; i < 7; i++) begin
         ex      = none;
         ex.sum  = dir[i].sum;
         ex.cout = dir[i].co;
         ex.ovf  = dir[i].ov;
         acc     = 1'b0;
         for (int t = 0; t < 20 && !acc; t++)
            offer(1'b1, dir[i].a, dir[i].b, dir[i].ci, dir[i].s, 1'b1, 1'b1, ex, acc);
         check("directed_accept", acc, 1);
      end
      drain();

      // Four-beat burst with the consumer stalled in cycles 3..5.
      lat_mode = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bx[i] = rnd_op();
         by[i] = rnd_op();
      end
      sent = 0;
      for (int i = 0; i < 12; i++) begin
         offer(sent < 4, bx[sent % 4], by[sent % 4], 1'b0, 1'b0,
               !(i >= 3 && i <= 5), 1'b0, none, acc);
         if (i >= 3 && i <= 5) check("stall_in_ready", in_ready, 0);
         if (acc) sent++;
      end
      check("burst_accepted", sent, 4);
      drain();

      // Reset with two beats in flight: nothing may emerge afterwards.
      offer(1'b1, rnd_op(), rnd_op(), 1'b0, 1'b0, 1'b1, 1'b0, none, acc);
      offer(1'b1, rnd_op(), rnd_op(), 1'b1, 1'b0, 1'b1, 1'b0, none, acc);
      @(negedge clk);
      in_valid = 1'b0;
      #1 rst_n = 1'b0;
      sb.delete();
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_sum", sum, 0);
      check("midrst_cout", cout, 0);
      check("midrst_in_ready", in_ready, 1);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         offer(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, none, acc);
         check("flushed_out_valid", out_valid, 0);
      end

      // Random traffic with random backpressure; offered data held until taken.
      pend = 1'b0;
      rx = '0; ry = '0; rc = 1'b0; rs = 1'b0; rv = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (!pend) begin
            rv = ($urandom_range(0, 3) != 0);
            rx = rnd_op();
            ry = rnd_op();
            rc = 1'($urandom);
            rs = 1'($urandom);
         end
         offer(rv, rx, ry, rc, rs, ($urandom_range(0, 9) < 7), 1'b0, none, acc);
         pend = rv && !acc;
      end
      drain();

      // Random traffic with bubbles and no backpressure (exact latency).
      lat_mode = 1'b1;
      for (int i = 0; i < 80; i++) begin
         offer(($urandom_range(0, 2) != 0), rnd_op(), rnd_op(), 1'($urandom), 1'($urandom),
               1'b1, 1'b0, none, acc);
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
